// File: rtl/activation_pkg.sv
// Shared types and constants for the activation pipeline.
package activation_pkg;

    // Activation selector. Codes 101..111 are reserved and produce zero.
    typedef enum logic [2:0] {
        ACT_RELU     = 3'd0,
        ACT_BINARY   = 3'd1,
        ACT_IDENTITY = 3'd2,
        ACT_LEAKY    = 3'd3,
        ACT_CLIP     = 3'd4
    } act_mode_t;

    // LEAKY slope after reset is 1/2.
    localparam int ACT_DEFAULT_SHIFT = 1;

    // Packed width of a configuration word {mode, thresh, shift, clip}.
    // The struct itself is declared in each module from its own DW/SW so
    // the layout always matches this width.
    function automatic int act_cfg_width(input int dw, input int sw);
        return 3 + dw + sw + dw;
    endfunction

endpackage

// File: rtl/activation_lane.sv
// Single-lane activation function: purely combinational, one instance
// per lane between the input register and the output register.
module activation_lane
    import activation_pkg::*;
#(
    parameter int DW    = 8,
    parameter int SW    = $clog2(DW),
    parameter int CFG_W = act_cfg_width(DW, SW)
) (
    input  logic signed [DW-1:0] x,
    input  logic [CFG_W-1:0]     cfg,
    output logic signed [DW-1:0] y,
    output logic                 clipped
);

    typedef struct packed {
        act_mode_t          mode;
        logic signed [DW-1:0] thresh;
        logic [SW-1:0]      shift;
        logic signed [DW-1:0] clip;
    } act_cfg_t;

    act_cfg_t             c;
    logic signed [DW-1:0] thresh_s;
    logic signed [DW-1:0] clip_s;
    logic signed [DW-1:0] clip_eff;
    logic signed [DW-1:0] leaky_y;

    assign c        = act_cfg_t'(cfg);
    assign thresh_s = $signed(c.thresh);
    assign clip_s   = $signed(c.clip);

    // A negative ceiling behaves as a ceiling of zero.
    assign clip_eff = clip_s[DW-1] ? '0 : clip_s;

    // Arithmetic shift rounds toward minus infinity, so -1 stays -1.
    assign leaky_y  = x >>> c.shift;

    // Select the activation for this lane and flag ceiling substitution.
    always_comb begin
        y       = '0;
        clipped = 1'b0;
        case (c.mode)
            ACT_RELU: begin
                y = x[DW-1] ? '0 : x;
            end
            ACT_BINARY: begin
                y = (x > thresh_s) ? '1 : '0;
            end
            ACT_IDENTITY: begin
                y = x;
            end
            ACT_LEAKY: begin
                y = x[DW-1] ? leaky_y : x;
            end
            ACT_CLIP: begin
                if (!x[DW-1]) begin
                    if (x > clip_eff) begin
                        y       = clip_eff;
                        clipped = 1'b1;
                    end else begin
                        y = x;
                    end
                end
            end
            default: begin
                y = '0;
            end
        endcase
    end

endmodule

// File: rtl/activation_pipe.sv
// Two-stage pipelined activation block with valid/ready on both sides,
// a configuration register loadable only while drained, and a saturating
// count of lanes replaced by the CLIP ceiling.
module activation_pipe
    import activation_pkg::*;
#(
    parameter int LANES = 8,
    parameter int DW    = 8,
    parameter int CW    = 16,
    parameter int SW    = $clog2(DW)
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [2:0]              cfg_mode,
    input  logic signed [DW-1:0]    cfg_thresh,
    input  logic [SW-1:0]           cfg_shift,
    input  logic signed [DW-1:0]    cfg_clip,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*DW-1:0]     in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*DW-1:0]     out_data,
    output logic [CW-1:0]           clip_count,
    input  logic                    clip_clear
);

    localparam int CFG_W = act_cfg_width(DW, SW);
    localparam int CNT_W = $clog2(LANES + 1);

    typedef struct packed {
        act_mode_t          mode;
        logic signed [DW-1:0] thresh;
        logic [SW-1:0]      shift;
        logic signed [DW-1:0] clip;
    } act_cfg_t;

    // Add a per-beat increment to the counter, sticking at all-ones.
    function automatic logic [CW-1:0] sat_add(input logic [CW-1:0]    acc,
                                              input logic [CNT_W-1:0] inc);
        logic [CW:0] sum;
        sum = {1'b0, acc} + (CW+1)'(inc);
        return sum[CW] ? {CW{1'b1}} : sum[CW-1:0];
    endfunction

    // Number of lanes in a beat whose value was replaced by the ceiling.
    function automatic logic [CNT_W-1:0] count_ones(input logic [LANES-1:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int k = 0; k < LANES; k++) begin
            n = n + CNT_W'(v[k]);
        end
        return n;
    endfunction

    // Stage A: raw lanes as accepted from the bias-add stage.
    logic                   a_valid_q, a_valid_d;
    logic [LANES*DW-1:0]    a_data_q,  a_data_d;

    // Stage B: activated lanes presented downstream.
    logic                   b_valid_q, b_valid_d;
    logic [LANES*DW-1:0]    b_data_q,  b_data_d;

    logic [CW-1:0]          clip_count_q, clip_count_d;
    act_cfg_t               cfg_q, cfg_d;

    logic [LANES*DW-1:0]    lane_y;
    logic [LANES-1:0]       lane_clip;
    logic [CNT_W-1:0]       clip_inc;

    logic                   b_adv;
    logic                   a_adv;
    logic                   a_load;
    logic                   b_load;
    logic                   cfg_load;

    // Stage B moves when empty or when downstream takes its beat; stage A
    // moves when empty or when B moves. Only out_ready reaches in_ready
    // combinationally; in_valid never reaches out_valid.
    assign b_adv     = !b_valid_q || out_ready;
    assign a_adv     = !a_valid_q || b_adv;
    assign in_ready  = a_adv;
    assign a_load    = a_adv && in_valid;
    assign b_load    = b_adv && a_valid_q;

    // Configuration only changes with nothing in flight and nothing
    // being offered, so every beat sees one consistent configuration.
    assign cfg_ready = !a_valid_q && !b_valid_q && !in_valid;
    assign cfg_load  = cfg_valid && cfg_ready;

    assign out_valid  = b_valid_q;
    assign out_data   = b_data_q;
    assign clip_count = clip_count_q;

    // ---- stage A -> stage B boundary: per-lane activation ----
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        activation_lane #(
            .DW    (DW),
            .SW    (SW),
            .CFG_W (CFG_W)
        ) u_lane (
            .x       (a_data_q[DW*k +: DW]),
            .cfg     (cfg_q),
            .y       (lane_y[DW*k +: DW]),
            .clipped (lane_clip[k])
        );
    end

    assign clip_inc = count_ones(lane_clip);

    // Next-state for both pipeline stages, the counter and the config.
    always_comb begin
        a_valid_d    = a_adv ? in_valid : a_valid_q;
        a_data_d     = a_load ? in_data : a_data_q;

        b_valid_d    = b_adv ? a_valid_q : b_valid_q;
        b_data_d     = b_load ? lane_y : b_data_q;

        clip_count_d = clip_count_q;
        if (clip_clear) begin
            clip_count_d = '0;
        end else if (b_load) begin
            clip_count_d = sat_add(clip_count_q, clip_inc);
        end

        cfg_d = cfg_q;
        if (cfg_load) begin
            cfg_d.mode   = act_mode_t'(cfg_mode);
            cfg_d.thresh = cfg_thresh;
            cfg_d.shift  = cfg_shift;
            cfg_d.clip   = cfg_clip;
        end
    end

    // Register update; reset empties the pipe and restores RELU defaults.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            a_valid_q    <= 1'b0;
            a_data_q     <= '0;
            b_valid_q    <= 1'b0;
            b_data_q     <= '0;
            clip_count_q <= '0;
            cfg_q.mode   <= ACT_RELU;
            cfg_q.thresh <= '0;
            cfg_q.shift  <= SW'(ACT_DEFAULT_SHIFT);
            cfg_q.clip   <= {1'b0, {(DW-1){1'b1}}};
        end else begin
            a_valid_q    <= a_valid_d;
            a_data_q     <= a_data_d;
            b_valid_q    <= b_valid_d;
            b_data_q     <= b_data_d;
            clip_count_q <= clip_count_d;
            cfg_q        <= cfg_d;
        end
    end

endmodule

// File: tb/tb_activation_pipe.sv
// Self-checking bench for activation_pipe: directed scenarios plus
// randomized traffic scored against a behavioural lane model.
module tb_activation_pipe;

    typedef int lanes_t [8];

    logic               clk;
    logic               n_rst;
    logic               cfg_valid;
    logic               cfg_ready;
    logic [2:0]         cfg_mode;
    logic signed [7:0]  cfg_thresh;
    logic [2:0]         cfg_shift;
    logic signed [7:0]  cfg_clip;
    logic               in_valid;
    logic               in_ready;
    logic [63:0]        in_data;
    logic               out_valid;
    logic               out_ready;
    logic [63:0]        out_data;
    logic [15:0]        clip_count;
    logic               clip_clear;

    int checks = 0;
    int errors = 0;

    // Behavioural model state.
    int          m_mode = 0;
    int          m_thr  = 0;
    int          m_sh   = 1;
    int          m_clip = 127;
    int          m_cnt  = 0;
    logic [63:0] exp_q[$];
    logic [63:0] last_out = '0;
    int          n_acc = 0;
    int          n_out = 0;
    logic        rand_bp = 1'b0;

    activation_pipe #(
        .LANES (8),
        .DW    (8),
        .CW    (16),
        .SW    (3)
    ) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_mode   (cfg_mode),
        .cfg_thresh (cfg_thresh),
        .cfg_shift  (cfg_shift),
        .cfg_clip   (cfg_clip),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .clip_count (clip_count),
        .clip_clear (clip_clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pk(input lanes_t v);
        logic [63:0] r;
        int          e;
        for (int k = 0; k < 8; k++) begin
            e = v[k];
            r[8*k +: 8] = e[7:0];
        end
        return r;
    endfunction

    // Reference activation of one lane value, plain integer arithmetic.
    function automatic int ref_lane(input int x);
        int c;
        int d;
        int q;
        c = (m_clip < 0) ? 0 : m_clip;
        case (m_mode)
            0: return (x < 0) ? 0 : x;
            1: return (x > m_thr) ? -1 : 0;
            2: return x;
            3: begin
                if (x >= 0) return x;
                d = 1 << m_sh;
                q = x / d;
                if (q * d != x) q = q - 1;
                return q;
            end
            4: return (x < 0) ? 0 : ((x > c) ? c : x);
            default: return 0;
        endcase
    endfunction

    function automatic logic [63:0] ref_out(input logic [63:0] d);
        logic [63:0] r;
        int          y;
        for (int k = 0; k < 8; k++) begin
            y = ref_lane(int'($signed(d[8*k +: 8])));
            r[8*k +: 8] = y[7:0];
        end
        return r;
    endfunction

    function automatic int ref_clips(input logic [63:0] d);
        int n;
        int x;
        int c;
        n = 0;
        c = (m_clip < 0) ? 0 : m_clip;
        for (int k = 0; k < 8; k++) begin
            x = int'($signed(d[8*k +: 8]));
            if (m_mode == 4 && x > c) n++;
        end
        return n;
    endfunction

    // Scoreboard: observe handshakes mid-cycle, away from the clock edge.
    initial begin
        forever begin
            @(negedge clk);
            if (n_rst) begin
                if (out_valid) begin
                    chk("beat_pending", 64'(exp_q.size() > 0), 64'd1);
                    if (exp_q.size() > 0) begin
                        chk("out_data", out_data, exp_q[0]);
                        if (out_ready) begin
                            last_out = out_data;
                            void'(exp_q.pop_front());
                            n_out++;
                        end
                    end
                end
                if (in_valid && in_ready) begin
                    exp_q.push_back(ref_out(in_data));
                    m_cnt = m_cnt + ref_clips(in_data);
                    if (m_cnt > 65535) m_cnt = 65535;
                    n_acc++;
                end
                if (cfg_valid && cfg_ready) begin
                    m_mode = int'(cfg_mode);
                    m_thr  = int'(cfg_thresh);
                    m_sh   = int'(cfg_shift);
                    m_clip = int'(cfg_clip);
                end
            end
        end
    end

    // Random downstream back-pressure when enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_bp) out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic send_beat(input logic [63:0] d);
        int   n;
        logic acc;
        n        = 0;
        acc      = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        forever begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
            n++;
            if (n > 1000) break;
        end
        in_valid = 1'b0;
        chk("in_accept", 64'(acc), 64'd1);
    endtask

    task automatic load_cfg(input int mode, input int thr, input int sh,
                            input int clip, output int w);
        logic acc;
        acc        = 1'b0;
        w          = 0;
        cfg_mode   = mode[2:0];
        cfg_thresh = thr[7:0];
        cfg_shift  = sh[2:0];
        cfg_clip   = clip[7:0];
        cfg_valid  = 1'b1;
        forever begin
            @(negedge clk);
            acc = cfg_ready;
            @(posedge clk);
            #1;
            if (acc) break;
            w++;
            if (w > 1000) break;
        end
        cfg_valid = 1'b0;
        chk("cfg_accept", 64'(acc), 64'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_done", 64'(n < 2000), 64'd1);
    endtask

    function automatic logic [63:0] rand_beat();
        return {$urandom, $urandom};
    endfunction

    initial begin
        lanes_t      l;
        lanes_t      e;
        logic [63:0] d;
        int          w;
        int          base_acc;
        int          base_out;

        n_rst      = 1'b0;
        cfg_valid  = 1'b0;
        cfg_mode   = '0;
        cfg_thresh = '0;
        cfg_shift  = '0;
        cfg_clip   = '0;
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b1;
        clip_clear = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_clip_count", 64'(clip_count), 64'd0);
        n_rst = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_in_ready", 64'(in_ready), 64'd1);
        chk("idle_cfg_ready", 64'(cfg_ready), 64'd1);

        // RELU after reset, with two-cycle latency check.
        l = '{-5, 0, 3, 127, -128, 1, -1, 64};
        e = '{0, 0, 3, 127, 0, 1, 0, 64};
        send_beat(pk(l));
        chk("relu_lat_c1", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        chk("relu_lat_c2", 64'(out_valid), 64'd1);
        chk("relu_data", out_data, pk(e));
        drain();
        chk("relu_clip_count", 64'(clip_count), 64'd0);

        // BINARY with positive then negative threshold.
        load_cfg(1, 10, 1, 127, w);
        l = '{10, 11, -20, 127, 0, -128, 50, 9};
        e = '{0, -1, 0, -1, 0, 0, -1, 0};
        send_beat(pk(l));
        drain();
        chk("binary_t10", last_out, pk(e));
        load_cfg(1, -3, 1, 127, w);
        l = '{-2, -3, -4, 0, -128, 127, -1, 5};
        e = '{-1, 0, 0, -1, 0, -1, -1, -1};
        send_beat(pk(l));
        drain();
        chk("binary_tm3", last_out, pk(e));

        // LEAKY with shift 2, then shift 0 as identity.
        load_cfg(3, 0, 2, 127, w);
        l = '{-8, -1, -128, 5, -7, 0, 127, -2};
        e = '{-2, -1, -32, 5, -2, 0, 127, -1};
        send_beat(pk(l));
        drain();
        chk("leaky_s2", last_out, pk(e));
        load_cfg(3, 0, 0, 127, w);
        send_beat(pk(l));
        drain();
        chk("leaky_s0", last_out, pk(l));

        // CLIP with counting, then clear colliding with a fourth beat.
        load_cfg(4, 0, 1, 6, w);
        l = '{7, 6, -4, 100, 0, 5, 127, 6};
        e = '{6, 6, 0, 6, 0, 5, 6, 6};
        send_beat(pk(l));
        send_beat(pk(l));
        send_beat(pk(l));
        drain();
        chk("clip_data", last_out, pk(e));
        chk("clip_count_9", 64'(clip_count), 64'd9);
        send_beat(pk(l));
        clip_clear = 1'b1;
        @(posedge clk);
        #1;
        clip_clear = 1'b0;
        m_cnt      = 0;
        chk("clear_vs_inc", 64'(clip_count), 64'd0);
        drain();
        chk("clear_hold", 64'(clip_count), 64'(m_cnt));

        // Negative ceiling acts as zero.
        load_cfg(4, 0, 1, -5, w);
        l = '{3, -1, 0, 0, 0, 0, 0, 0};
        e = '{0, 0, 0, 0, 0, 0, 0, 0};
        send_beat(pk(l));
        drain();
        chk("clip_neg_data", last_out, pk(e));
        chk("clip_neg_count", 64'(clip_count), 64'd1);

        // Back-pressure: six beats against a stalled output.
        load_cfg(2, 0, 1, 127, w);
        base_acc  = n_acc;
        base_out  = n_out;
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) send_beat(rand_beat());
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                chk("bp_accepted", 64'(n_acc - base_acc), 64'd2);
                chk("bp_in_ready", 64'(in_ready), 64'd0);
                chk("bp_out_valid", 64'(out_valid), 64'd1);
                out_ready = 1'b1;
            end
        join
        drain();
        chk("bp_all_out", 64'(n_out - base_out), 64'd6);

        // Config request while two beats are in flight.
        l = '{-9, 4, -1, 0, 8, -100, 2, -3};
        e = '{0, 4, 0, 0, 8, 0, 2, 0};
        send_beat(pk(l));
        send_beat(pk(l));
        chk("cfg_busy", 64'(cfg_ready), 64'd0);
        load_cfg(0, 0, 1, 127, w);
        chk("cfg_waited", 64'(w >= 2), 64'd1);
        send_beat(pk(l));
        drain();
        chk("cfg_new_mode", last_out, pk(e));

        // Random configurations and traffic with random back-pressure.
        for (int r = 0; r < 12; r++) begin
            load_cfg(int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
                     int'($urandom_range(0, 7)), int'($urandom_range(0, 255)), w);
            rand_bp = 1'b1;
            for (int i = 0; i < 25; i++) send_beat(rand_beat());
            rand_bp   = 1'b0;
            out_ready = 1'b1;
            drain();
            chk("rand_clip_count", 64'(clip_count), 64'(m_cnt));
        end

        // Drive the counter into saturation.
        clip_clear = 1'b1;
        @(posedge clk);
        #1;
        clip_clear = 1'b0;
        m_cnt      = 0;
        load_cfg(4, 0, 1, 6, w);
        for (int i = 0; i < 8200; i++) begin
            for (int k = 0; k < 8; k++) d[8*k +: 8] = 8'($urandom_range(7, 127));
            send_beat(d);
        end
        drain();
        chk("sat_count", 64'(clip_count), 64'hFFFF);
        chk("sat_model", 64'(clip_count), 64'(m_cnt));

        // Reset in the middle of traffic.
        load_cfg(2, 0, 3, 20, w);
        send_beat(rand_beat());
        send_beat(rand_beat());
        n_rst = 1'b0;
        exp_q.delete();
        m_mode = 0;
        m_thr  = 0;
        m_sh   = 1;
        m_clip = 127;
        m_cnt  = 0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_out_data", out_data, 64'd0);
        chk("midrst_clip_count", 64'(clip_count), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        @(posedge clk);
        #1;
        l = '{-5, 0, 3, 127, -128, 1, -1, 64};
        e = '{0, 0, 3, 127, 0, 1, 0, 64};
        send_beat(pk(l));
        drain();
        chk("midrst_relu", last_out, pk(e));
        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
